// File: rtl/alu_pipe_acc.sv
// alu_pipe_acc: registered ALU with an internal accumulator and valid/ready handshakes.
//
// This is the parametrised successor of the 6-bit combinational ALU and uses the
// same 3-bit fxn encoding. A single output register holds one result at a time.
// Because in_ready depends on out_ready, one operation can be accepted every cycle.
//
// Parameters:
//   WIDTH     operand, result and accumulator width in bits (>= 2)
//   SATURATE  1 = signed saturation when add, sub or negate overflows
//             0 = two's-complement wrap
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   in_valid         operation request valid
//   in_ready         the block can accept a request this cycle
//   fxn              operation select
//   a, b             operands (a is ignored when use_acc = 1)
//   use_acc          operand A is taken from the accumulator
//   acc_wr           on acceptance, the accumulator loads this op's final result
//   acc_clr          on acceptance, the accumulator clears to 0 (wins over acc_wr)
//   out_valid        result and flags are valid
//   out_ready        the consumer takes the result this cycle
//   result           registered result
//   flag_zero        result == 0
//   flag_neg         MSB of result
//   flag_carry       add: carry-out; sub: borrow (A < B unsigned); otherwise 0
//   flag_ovf         signed overflow on add, sub or negate; otherwise 0
//   acc_q            current accumulator value

module alu_pipe_acc #(
   parameter int unsigned WIDTH    = 6,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       fxn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             use_acc,
   input  logic             acc_wr,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_zero,
   output logic             flag_neg,
   output logic             flag_carry,
   output logic             flag_ovf,
   output logic [WIDTH-1:0] acc_q
);

   localparam int unsigned Msb = WIDTH - 1;

   localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] One    = {{(WIDTH-1){1'b0}}, 1'b1};

   localparam logic [2:0] FxnPassA = 3'b000;
   localparam logic [2:0] FxnPassB = 3'b001;
   localparam logic [2:0] FxnNegA  = 3'b010;
   localparam logic [2:0] FxnNegB  = 3'b011;
   localparam logic [2:0] FxnGtU   = 3'b100;
   localparam logic [2:0] FxnXnor  = 3'b101;
   localparam logic [2:0] FxnAdd   = 3'b110;
   localparam logic [2:0] FxnSub   = 3'b111;

   logic             accept;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] neg_a;
   logic [WIDTH-1:0] neg_b;

   // Pre-saturation result, the clamp value to use on overflow, and the final result.
   logic [WIDTH-1:0] raw_res;
   logic [WIDTH-1:0] sat_val;
   logic [WIDTH-1:0] res_d;
   logic             carry_d;
   logic             ovf_d;

   // There is one output register, so a new op can enter only when the slot is
   // empty or is being drained in this same cycle.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Reading the registered accumulator gives a back-to-back use_acc op the value
   // written by the previous accept, because both updates happen on the same edge.
   assign op_a = use_acc ? acc_q : a;
   assign op_b = b;

   assign sum   = {1'b0, op_a} + {1'b0, op_b};
   assign diff  = {1'b0, op_a} - {1'b0, op_b};
   assign neg_a = (~op_a) + One;
   assign neg_b = (~op_b) + One;

   always_comb begin
      raw_res = '0;
      sat_val = MaxPos;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      case (fxn)
         FxnPassA: raw_res = op_a;
         FxnPassB: raw_res = op_b;
         FxnNegA: begin
            raw_res = neg_a;
            ovf_d   = (op_a == MinNeg);
            sat_val = MaxPos;
         end
         FxnNegB: begin
            raw_res = neg_b;
            ovf_d   = (op_b == MinNeg);
            sat_val = MaxPos;
         end
         FxnGtU:  raw_res = {{(WIDTH-1){1'b0}}, (op_a > op_b)};
         FxnXnor: raw_res = ~(op_a ^ op_b);
         FxnAdd: begin
            raw_res = sum[WIDTH-1:0];
            carry_d = sum[WIDTH];
            ovf_d   = (op_a[Msb] == op_b[Msb]) && (sum[Msb] != op_a[Msb]);
            // An overflowing add has the sign of both operands.
            sat_val = op_a[Msb] ? MinNeg : MaxPos;
         end
         FxnSub: begin
            raw_res = diff[WIDTH-1:0];
            carry_d = diff[WIDTH];
            ovf_d   = (op_a[Msb] != op_b[Msb]) && (diff[Msb] != op_a[Msb]);
            // An overflowing subtract has the sign of the minuend.
            sat_val = op_a[Msb] ? MinNeg : MaxPos;
         end
      endcase
   end

   assign res_d = (SATURATE && ovf_d) ? sat_val : raw_res;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         result     <= '0;
         flag_zero  <= 1'b0;
         flag_neg   <= 1'b0;
         flag_carry <= 1'b0;
         flag_ovf   <= 1'b0;
         acc_q      <= '0;
      end else begin
         if (accept) begin
            out_valid  <= 1'b1;
            result     <= res_d;
            flag_zero  <= (res_d == '0);
            flag_neg   <= res_d[Msb];
            flag_carry <= carry_d;
            flag_ovf   <= ovf_d;
            if (acc_clr) begin
               acc_q <= '0;
            end else if (acc_wr) begin
               acc_q <= res_d;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe_acc.sv
// Testbench for alu_pipe_acc. Two instances are driven with the same stimulus: one
// with SATURATE=0 and one with SATURATE=1. Each instance has its own reference model
// and its own expected-response queue.
module tb_alu_pipe_acc;

   localparam int W = 6;

   typedef struct packed {
      logic [W-1:0] res;
      logic         z;
      logic         n;
      logic         c;
      logic         v;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [2:0]   fxn;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         use_acc;
   logic         acc_wr;
   logic         acc_clr;
   logic         out_ready;

   logic         ov [2];
   logic         ir [2];
   logic [W-1:0] rs [2];
   logic         fz [2];
   logic         fn [2];
   logic         fc [2];
   logic         fv [2];
   logic [W-1:0] aq [2];

   exp_t         q0[$];
   exp_t         q1[$];
   logic [W-1:0] macc [2];
   bit           mon_en;
   int           errors;
   int           checks;

   alu_pipe_acc #(.WIDTH(W), .SATURATE(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .fxn(fxn),
      .a(a), .b(b), .use_acc(use_acc), .acc_wr(acc_wr), .acc_clr(acc_clr),
      .out_valid(ov[0]), .out_ready(out_ready), .result(rs[0]), .flag_zero(fz[0]),
      .flag_neg(fn[0]), .flag_carry(fc[0]), .flag_ovf(fv[0]), .acc_q(aq[0])
   );

   alu_pipe_acc #(.WIDTH(W), .SATURATE(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .fxn(fxn),
      .a(a), .b(b), .use_acc(use_acc), .acc_wr(acc_wr), .acc_clr(acc_clr),
      .out_valid(ov[1]), .out_ready(out_ready), .result(rs[1]), .flag_zero(fz[1]),
      .flag_neg(fn[1]), .flag_carry(fc[1]), .flag_ovf(fv[1]), .acc_q(aq[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   // Reference model. It works on signed integers: overflow means the true value
   // falls outside the signed W-bit range, and the result is the true value
   // truncated to W bits (or clamped when saturating).
   function automatic exp_t model(input logic [2:0] f, input logic [W-1:0] xa,
                                  input logic [W-1:0] xb, input bit sat);
      exp_t e;
      int ua, ub, sa, sb, t, r;
      bit c, v;
      ua = int'(xa);
      ub = int'(xb);
      sa = (ua >= 32) ? ua - 64 : ua;
      sb = (ub >= 32) ? ub - 64 : ub;
      c = 1'b0;
      v = 1'b0;
      r = 0;
      case (f)
         3'd0: r = ua;
         3'd1: r = ub;
         3'd2: begin t = -sa; v = (t > 31); r = (sat && v) ? 31 : t; end
         3'd3: begin t = -sb; v = (t > 31); r = (sat && v) ? 31 : t; end
         3'd4: r = (ua > ub) ? 1 : 0;
         3'd5: r = (~(ua ^ ub)) & 63;
         3'd6: begin
            t = sa + sb;
            c = (ua + ub) > 63;
            v = (t > 31) || (t < -32);
            r = (sat && v) ? ((t > 0) ? 31 : -32) : t;
         end
         default: begin
            t = sa - sb;
            c = (ua < ub);
            v = (t > 31) || (t < -32);
            r = (sat && v) ? ((t > 0) ? 31 : -32) : t;
         end
      endcase
      e.res = r[W-1:0];
      e.z   = (e.res == '0);
      e.n   = e.res[W-1];
      e.c   = c;
      e.v   = v;
      return e;
   endfunction

   // Issue side: an accept takes effect at the next rising edge, so push the
   // expected response and advance the model accumulator now.
   always @(negedge clk) begin
      #1;
      if (mon_en && rst_n && in_valid && ir[0]) begin
         for (int k = 0; k < 2; k++) begin
            logic [W-1:0] opa;
            exp_t         e;
            opa = use_acc ? macc[k] : a;
            e = model(fxn, opa, b, k == 1);
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
            if (acc_clr)     macc[k] = '0;
            else if (acc_wr) macc[k] = e.res;
         end
      end
   end

   task automatic mon_dut(input int k, input int qsize, input exp_t front, output bit pop);
      pop = 1'b0;
      chk($sformatf("dut%0d out_valid", k), ov[k], (qsize != 0) ? 1 : 0);
      chk($sformatf("dut%0d in_ready", k), ir[k], ((qsize == 0) || out_ready) ? 1 : 0);
      chk($sformatf("dut%0d acc_q", k), aq[k], macc[k]);
      if (ov[k] && qsize != 0) begin
         chk($sformatf("dut%0d result", k), rs[k], front.res);
         chk($sformatf("dut%0d flags_zncv", k), {fz[k], fn[k], fc[k], fv[k]},
             {front.z, front.n, front.c, front.v});
         pop = out_ready;
      end
   endtask

   // Monitor: outputs are held between edges. A transfer happens at the next
   // rising edge whenever out_valid and out_ready are both high.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         exp_t f0, f1;
         bit   p0, p1;
         f0 = (q0.size() != 0) ? q0[0] : '0;
         f1 = (q1.size() != 0) ? q1[0] : '0;
         mon_dut(0, q0.size(), f0, p0);
         mon_dut(1, q1.size(), f1, p1);
         if (p0) void'(q0.pop_front());
         if (p1) void'(q1.pop_front());
      end
   end

   task automatic op(input logic [2:0] f, input logic [W-1:0] aa, input logic [W-1:0] bb,
                     input logic ua, input logic wr, input logic clr);
      bit ok;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      fxn = f;
      a = aa;
      b = bb;
      use_acc = ua;
      acc_wr = wr;
      acc_clr = clr;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #2;
         if (ir[0]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("op accept timeout", 0, 1);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      mon_en = 1'b0;
      macc[0] = '0;
      macc[1] = '0;
      rst_n = 1'b1;
      in_valid = 1'b0;
      fxn = '0;
      a = '0;
      b = '0;
      use_acc = 1'b0;
      acc_wr = 1'b0;
      acc_clr = 1'b0;
      out_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("reset out_valid", ov[k], 0);
         chk("reset result", rs[k], 0);
         chk("reset flags", {fz[k], fn[k], fc[k], fv[k]}, 0);
         chk("reset acc_q", aq[k], 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1'b1;
      #1 chk("in_ready after reset", ir[0], 1);

      // Subtract with borrow, then unsigned greater-than on the same operands.
      op(3'b111, 6'd18, 6'd19, 1'b0, 1'b0, 1'b0);
      idle();
      chk("sub result", rs[0], 63);
      chk("sub flags_zncv", {fz[0], fn[0], fc[0], fv[0]}, 4'b0110);
      op(3'b100, 6'd18, 6'd19, 1'b0, 1'b0, 1'b0);
      idle();
      chk("gt result", rs[0], 0);
      chk("gt zero", fz[0], 1);

      // Add overflow: wrap versus saturate.
      op(3'b110, 6'd31, 6'd1, 1'b0, 1'b0, 1'b0);
      idle();
      chk("add ovf wrap result", rs[0], 32);
      chk("add ovf wrap ovf/carry", {fv[0], fc[0]}, 2'b10);
      chk("add ovf sat result", rs[1], 31);
      chk("add ovf sat ovf", fv[1], 1);

      // Negating the most negative value.
      op(3'b010, 6'd32, 6'd0, 1'b0, 1'b0, 1'b0);
      idle();
      chk("neg min wrap result", rs[0], 32);
      chk("neg min wrap ovf", fv[0], 1);
      chk("neg min sat result", rs[1], 31);

      // Accumulator chain issued back to back.
      op(3'b000, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         op(3'b110, 6'd0, 6'd5, 1'b1, 1'b1, 1'b0);
         if (i > 0) chk("acc chain result", rs[0], 5 * i);
      end
      idle();
      chk("acc chain last result", rs[0], 15);
      chk("acc chain acc_q", aq[0], 15);
      chk("acc chain acc_q sat", aq[1], 15);

      // Backpressure: stall for 4 cycles, then drain and accept in the same cycle.
      repeat (2) @(posedge clk);
      #1 out_ready = 1'b0;
      op(3'b001, 6'd0, 6'd9, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      fxn = 3'b001;
      b = 6'd33;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #2;
         chk("stall in_ready", ir[0], 0);
         chk("stall result", rs[0], 9);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      #2 chk("drain+accept in_ready", ir[0], 1);
      idle();
      chk("drain+accept out_valid", ov[0], 1);
      chk("drain+accept result", rs[0], 33);

      // Asynchronous reset in the middle of a stall, with a non-zero accumulator.
      op(3'b001, 6'd0, 6'd7, 1'b0, 1'b1, 1'b0);
      out_ready = 1'b0;
      idle();
      @(posedge clk);
      #3;
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("mid reset out_valid", ov[k], 0);
         chk("mid reset result", rs[k], 0);
         chk("mid reset flags", {fz[k], fn[k], fc[k], fv[k]}, 0);
         chk("mid reset acc_q", aq[k], 0);
      end
      q0.delete();
      q1.delete();
      macc[0] = '0;
      macc[1] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("in_ready after mid reset", ir[0], 1);
      out_ready = 1'b1;
      mon_en = 1'b1;

      // Random traffic, checked by the scoreboard.
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 4) != 0;
         fxn       = 3'($urandom);
         a         = 6'($urandom);
         b         = 6'($urandom);
         use_acc   = 1'($urandom);
         acc_wr    = 1'($urandom);
         acc_clr   = ($urandom % 8) == 0;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard drained dut0", q0.size(), 0);
      chk("scoreboard drained dut1", q1.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_pipe_acc.md
Name: alu_pipe_acc

Overview:
- Parametrised, registered successor to the team's 6-bit combinational ALU. Keeps the same 3-bit fxn encoding.
- Adds:
  - WIDTH generalisation
  - valid/ready handshakes on input and output
  - one-cycle registered result
  - status flags
  - optional signed saturation
  - internal accumulator that can replace operand A
- Sits between an operand sequencer and a result consumer. The accumulator enables multi-step arithmetic without external feedback.

Parameters:
WIDTH, 6, operand/result/accumulator width in bits (>=2)
SATURATE, 0, 1 = signed saturation on add/sub/negate overflow; 0 = two's-complement wrap

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept a request this cycle
fxn  input  3  operation select
a  input  WIDTH  operand A (ignored when use_acc=1)
b  input  WIDTH  operand B
use_acc  input  1  1 = operand A taken from accumulator
acc_wr  input  1  1 = accumulator loads this op's result on acceptance
acc_clr  input  1  1 = accumulator cleared to 0 on acceptance (priority over acc_wr)
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result this cycle
result  output  WIDTH  registered result
flag_zero  output  1  result == 0
flag_neg  output  1  result MSB
flag_carry  output  1  add: unsigned carry-out; sub: unsigned borrow (A<B); else 0
flag_ovf  output  1  signed overflow (add/sub/negate); else 0
acc_q  output  WIDTH  current accumulator value

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, result=0, all flags=0, acc_q=0.
  - Any in-flight result is discarded.
  - in_ready=1 once reset deasserts.
- Operand selection: opA = use_acc ? acc_q : a; opB = b.
- fxn encoding:
  - 000 opA
  - 001 opB
  - 010 -opA
  - 011 -opB
  - 100 {0..0, (opA>opB unsigned)}
  - 101 ~(opA^opB)
  - 110 opA+opB
  - 111 opA-opB
- Arithmetic: computed at WIDTH+1 bits.
  - Carry/borrow = bit WIDTH.
  - Add overflow = operands share a sign and the result sign differs.
  - Sub overflow = operand signs differ and the result sign differs from opA.
  - Negate overflow = operand equals 100..0.
- SATURATE=1 on overflow:
  - Result clamps to 011..1 if the true value is positive, else 100..0.
  - Negate of 100..0 gives 011..1.
  - flag_ovf still reports 1. carry unaffected.
- Flags are computed on the final (possibly saturated) result for zero/neg.
- Handshake:
  - Accept = in_valid & in_ready. in_ready = !out_valid | out_ready (single output register, full throughput).
  - On accept: result/flags load next edge, out_valid=1. Latency is exactly 1 cycle.
  - On out_valid & out_ready with no accept in the same cycle: out_valid goes to 0 next edge.
  - Simultaneous drain and accept: register reloads, out_valid stays 1, no bubble.
  - While out_valid=1 & out_ready=0: result, flags and out_valid hold stable. in_ready=0.
- Accumulator:
  - Updates only on accept, on the same edge as the result register.
  - A back-to-back op with use_acc=1 sees the just-accepted value; there is no hazard.
  - acc_clr=1 -> 0. Else acc_wr=1 -> final result. Else hold.
  - Inputs without accept have no effect.
- X on fxn is not permitted when in_valid=1. Inputs other than in_valid and out_ready are don't-care when not accepted.

Test Plan:
- WIDTH=6, a=010010, b=010011, fxn=111, out_ready=1 -> next cycle result=111111, carry=1, neg=1, ovf=0, zero=0; fxn=100 same operands -> result=000000, zero=1.
- WIDTH=6, SATURATE=0: a=011111, b=000001, fxn=110 -> result=100000, ovf=1, carry=0. Repeat with SATURATE=1 -> result=011111, ovf=1.
- fxn=010, a=100000 -> SATURATE=0: result=100000, ovf=1; SATURATE=1: result=011111.
- Accumulator chain: acc_clr op, then three back-to-back ops fxn=110, use_acc=1, acc_wr=1, b=000101 -> results 000101, 001010, 001111 on consecutive cycles; acc_q=001111.
- Backpressure: hold out_ready=0 for 4 cycles after one accept -> in_ready=0, result stable, second in_valid not accepted. Raise out_ready with in_valid=1 -> drain and accept in the same cycle; out_valid stays 1.
- Pull rst_n low mid-stall with out_valid=1 and acc_q!=0 -> out_valid, result, flags and acc_q go to 0 immediately (asynchronous). After release, in_ready=1.
